// File: rtl/shift_mux_scheduler.sv
// Round-robin scheduler sharing one external combinational left shifter among N_REQ requesters.
// Stage 1 holds the granted operand/width for the shifter; stage 2 captures the result for a backpressured output.
module shift_mux_scheduler #(
  parameter int DATA_W  = 8,
  parameter int SHIFT_W = 3,
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic [N_REQ*SHIFT_W-1:0]   req_shift,
  output logic [N_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]          sh_a,
  output logic [SHIFT_W-1:0]         sh_width,
  input  logic [DATA_W-1:0]          sh_result,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [ID_W-1:0]            out_id,
  input  logic                       out_ready,
  output logic                       busy,
  output logic [15:0]                grant_cnt
);

  logic               s1_valid_q,  s1_valid_d;
  logic [DATA_W-1:0]  sh_a_q,      sh_a_d;
  logic [SHIFT_W-1:0] sh_width_q,  sh_width_d;
  logic [ID_W-1:0]    s1_id_q,     s1_id_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q,  out_data_d;
  logic [ID_W-1:0]    out_id_q,    out_id_d;
  logic [ID_W-1:0]    rr_ptr_q,    rr_ptr_d;
  logic [15:0]        grant_cnt_q, grant_cnt_d;

  logic               s2_load;
  logic               s1_load;
  logic               grant_found;
  logic               accept;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    cand_idx;
  logic [ID_W:0]      cand_sum;
  logic [N_REQ-1:0]   grant_oh;

  // Stage 2 frees when empty or draining; stage 1 frees when empty or moving into stage 2.
  assign s2_load = s1_valid_q & (~out_valid_q | out_ready);
  assign s1_load = ~s1_valid_q | s2_load;

  // Search from rr_ptr upward with wrap; the extra sum bit keeps the wrap test exact for any N_REQ.
  always_comb begin : arbiter
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand_sum >= (ID_W+1)'(N_REQ)) begin
        cand_sum = cand_sum - (ID_W+1)'(N_REQ);
      end
      cand_idx = cand_sum[ID_W-1:0];
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign accept = grant_found & s1_load;

  // Reset gates the grant combinationally: stage 1 looks empty during reset.
  always_comb begin
    grant_oh = '0;
    if (Reset && accept) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    sh_a_d      = sh_a_q;
    sh_width_d  = sh_width_q;
    s1_id_d     = s1_id_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    rr_ptr_d    = rr_ptr_q;
    grant_cnt_d = grant_cnt_q;

    if (s1_load) begin
      s1_valid_d = accept;
      if (accept) begin
        sh_a_d      = req_data[int'(grant_idx)*DATA_W +: DATA_W];
        sh_width_d  = req_shift[int'(grant_idx)*SHIFT_W +: SHIFT_W];
        s1_id_d     = grant_idx;
        rr_ptr_d    = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
        grant_cnt_d = grant_cnt_q + 16'd1;
      end
    end

    if (s2_load) begin
      out_valid_d = 1'b1;
      out_data_d  = sh_result;
      out_id_d    = s1_id_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      s1_valid_q  <= 1'b0;
      sh_a_q      <= '0;
      sh_width_q  <= '0;
      s1_id_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      rr_ptr_q    <= '0;
      grant_cnt_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      sh_a_q      <= sh_a_d;
      sh_width_q  <= sh_width_d;
      s1_id_q     <= s1_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign req_ready = grant_oh;
  assign sh_a      = sh_a_q;
  assign sh_width  = sh_width_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = s1_valid_q | out_valid_q;
  assign grant_cnt = grant_cnt_q;

endmodule

// File: doc/shift_mux_scheduler.md
Name: shift_mux_scheduler

Overview:
- Round-robin scheduler that shares one external combinational variable_shift_mux (left shift, result truncated to DATA_W) among N_REQ requesters.
- Accepts operand/shift-width pairs over valid/ready handshakes and registers the granted operand so the shifter sees stable inputs.
- Captures the shifter result and returns it with the requester ID through a backpressured output port.
- Two-stage pipeline. Sits between producer blocks and the shared shift resource.

Parameters:
- DATA_W, 8, operand/result width.
- SHIFT_W, 3, shift-width field; shift range 0..2^SHIFT_W-1.
- N_REQ, 4, number of requesters; legal 2..8.
- ID_W, 2, requester ID width; must equal ceil(log2(N_REQ)).

Ports:
- clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_data  input  N_REQ*DATA_W  operand; requester i occupies [i*DATA_W +: DATA_W].
- req_shift  input  N_REQ*SHIFT_W  shift width; requester i occupies [i*SHIFT_W +: SHIFT_W].
- req_ready  output  N_REQ  one-hot grant; transfer on req_valid[i] & req_ready[i].
- sh_a  output  DATA_W  operand to the shared shifter (stage-1 register).
- sh_width  output  SHIFT_W  shift width to the shared shifter (stage-1 register).
- sh_result  input  DATA_W  combinational shifter result, sh_a << sh_width.
- out_valid  output  1  result valid.
- out_data  output  DATA_W  registered result.
- out_id  output  ID_W  requester ID of out_data.
- out_ready  input  1  downstream accepts; transfer on out_valid & out_ready.
- busy  output  1  s1_valid | out_valid.
- grant_cnt  output  16  total accepted requests; wraps 16'hFFFF -> 16'h0000.

Behaviour:
- Reset (Reset=0, async): s1_valid=0, sh_a=0, sh_width=0, s1_id=0, out_valid=0, out_data=0, out_id=0, rr_ptr=0, grant_cnt=0. req_ready=0 while in reset.
- Pipeline control:
  - s2_load = s1_valid & (!out_valid | out_ready).
  - s1_load = !s1_valid | s2_load.
- Arbitration (combinational):
  - When s1_load=1, search req_valid starting at index rr_ptr, ascending with wrap at N_REQ-1 -> 0.
  - The first set bit wins and only that bit of req_ready goes high.
  - req_ready is all-zero when s1_load=0 or no request is present.
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- On accept of requester g at edge N:
  - sh_a<=req_data[g], sh_width<=req_shift[g], s1_id<=g, s1_valid<=1.
  - rr_ptr<=(g+1) mod N_REQ.
  - grant_cnt<=grant_cnt+1.
- No accept while s1_load=1: s1_valid<=0; sh_a/sh_width hold their values.
- s2_load at edge N+1: out_data<=sh_result, out_id<=s1_id, out_valid<=1.
- Output drain: out_valid & out_ready with no s2_load gives out_valid<=0; out_data and out_id hold.
- Latency: accept to out_valid is 2 cycles. Sustained throughput is 1 result/cycle while out_ready=1.
- Backpressure (out_ready=0, out_valid=1): out regs hold, stage 1 holds (sh_a/sh_width stable), req_ready=0. The pipeline absorbs at most 2 entries.
- Simultaneous drain and load: out_valid stays 1 and takes the new data; no bubble.
- rr_ptr advances only on an accept. An idle requester keeps its priority position.
- Shifts of 0 pass the operand through; shifts at or beyond DATA_W are not possible with the defaults. Truncation is performed by the external shifter; the scheduler does no arithmetic on data.
- A req_valid dropped without a transfer is legal; no state change.
- Reset asserted mid-operation: in-flight entries are discarded immediately and no output transfer completes.

Test Plan:
- Reset release, requester 0 alone with data 8'h81, shift 1 -> sh_a=8'h81 one cycle after accept; out_valid, out_data=8'h02, out_id=0 two cycles after accept; grant_cnt=1.
- All 4 requesters valid continuously, out_ready=1 -> grants 0,1,2,3,0,1... one per cycle; out_id follows the same order; no bubbles.
- Requesters 1 and 3 valid, rr_ptr=2 -> 3 granted first, then 1.
- out_ready=0 for 5 cycles with requests pending -> exactly 2 accepts, then req_ready=0. sh_a, out_data and out_id stay stable. On release, results arrive in order with no loss or duplication.
- Sweep requester 2 data 8'hFF with shifts 0..7 -> out_data FF,FE,FC,F8,F0,E0,C0,80 each with out_id=2; compare against the behavioural a<<shift.
- Reset pulsed low while out_valid=1 -> all outputs zero asynchronously. After release the first grant goes to the lowest valid index from 0; grant_cnt restarts at 0. Separately, preload 16'hFFFF grants -> next accept wraps grant_cnt to 0.
